ps2_tx: RTL and testbench
=========================

# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the host to the keyboard using the open-drain PS/2 request-to-send sequence. It shares the `ps2c`/`ps2d` lines with the keyboard receive path. The receiver must be gated with `rx_en = tx_idle` so the transmitter's own frame is never decoded as a scan code. Each transfer ends with a done tick carrying acknowledge and timeout status.

## Interface
- `RTS_CYCLES`, 5000 — clock-low inhibit time before the start bit (100 µs at 50 MHz); minimum 2.
- `TIMEOUT_CYCLES`, 750000 — maximum `clk` cycles between consecutive filtered `ps2c` falling edges while waiting for the device (15 ms at 50 MHz).
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `wr_ps2` in 1 — start-transfer strobe; sampled only in `idle`.
- `din` in 8 — command byte; captured on the accepted `wr_ps2` cycle.
- `ps2c` in 1 — PS/2 clock line level (already synchronised externally).
- `ps2d` in 1 — PS/2 data line level.
- `ps2c_oe` out 1 — 1 = drive `ps2c` low; 0 = release (pull-up).
- `ps2d_oe` out 1 — 1 = drive `ps2d` low; 0 = release.
- `tx_idle` out 1 — 1 when in `idle` and ready for `wr_ps2`.
- `tx_done_tick` out 1 — one-cycle pulse when a transfer finishes or aborts.
- `ack_err` out 1 — registered; valid from `tx_done_tick` until the next accepted `wr_ps2`; 1 = device did not ACK.
- `timeout_err` out 1 — registered; same validity; 1 = transfer aborted on timeout.

## Operation
- **Clock filter:** 8-bit shift register of `ps2c` samples. Filtered value goes to 1 when all bits are 1 and to 0 when all are 0; otherwise it holds. `fall_edge` is a one-cycle pulse on a filtered 1→0 transition. The filter runs in every state.
- **Frame:** 9-bit shift register `{parity, din}`, shifted out LSB first. Parity is odd: `~^din`. The stop bit is supplied by releasing `ps2d`.
- **FSM states** (`ps2c_oe` / `ps2d_oe` are decoded from state plus the current bit):
  - `idle` — both released; `tx_idle` = 1. On `wr_ps2`: load the shift register, load the delay counter with `RTS_CYCLES-1`, clear `ack_err` and `timeout_err`, go to `rts`.
  - `rts` — `ps2c_oe` = 1, `ps2d_oe` = 0. Decrement the counter. At 0, go to `start` and load the watchdog.
  - `start` — `ps2c_oe` = 0, `ps2d_oe` = 1 (start bit 0). On `fall_edge`: bit counter = 8, go to `data`.
  - `data` — `ps2d_oe` = ~shift[0]. On `fall_edge`: shift right. If the bit counter is 0, go to `stop`; otherwise decrement it.
  - `stop` — both released (stop bit 1). On `fall_edge`: `ack_err` = `ps2d` sampled that cycle (0 = ACK), pulse `tx_done_tick`, go to `idle`.
- **Watchdog:** 20-bit down counter, active in `start`, `data` and `stop`, reloaded to `TIMEOUT_CYCLES-1` on every `fall_edge`. On reaching 0: `timeout_err` = 1, `ack_err` = 1, pulse `tx_done_tick`, release both lines, go to `idle`.
- `wr_ps2` outside `idle` is ignored (not queued). `din` is not re-read after capture.
- Both lines must never be driven low at once outside `rts`.

## Timing
- **Reset values:** state = `idle`, `ps2c_oe` = 0, `ps2d_oe` = 0, `tx_idle` = 1, `tx_done_tick` = 0, `ack_err` = 0, `timeout_err` = 0, filter = all ones.
- **Reset mid-transfer:** lines are released asynchronously (outputs decode from a state that resets immediately). No done tick is generated.
- `tx_idle` falls in the cycle after `wr_ps2` is accepted. `ps2c_oe` asserts in that same cycle and stays high for exactly `RTS_CYCLES` cycles. `ps2d_oe` rises on the cycle `ps2c_oe` falls.
- **Data bits:** each new data bit appears on `ps2d_oe` the cycle after the `fall_edge` that consumed the previous bit. Total: 1 start + 8 data + 1 parity driven bits, then the stop bit.
- `fall_edge` lags the raw `ps2c` fall by 9 `clk` cycles.
- `tx_done_tick` asserts the cycle after the 11th `fall_edge` following `rts`; `tx_idle` = 1 in that same cycle.
- **Back-to-back:** `wr_ps2` in the `tx_done_tick` cycle is accepted.

## Test plan
- `RTS_CYCLES`=20. `wr_ps2` with `din`=0xED → `ps2c_oe` high for 20 cycles. Device model then clocks 11 falling edges and pulls `ps2d` low on the last one. Sampled data = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. `tx_done_tick` pulses; `ack_err` = 0.
- `din`=0xF4 → sampled bits LSB first 0,0,1,0,1,1,1,1; parity 0; done with `ack_err` = 0.
- Device leaves `ps2d` high on the ACK clock → `ack_err` = 1, `timeout_err` = 0.
- `TIMEOUT_CYCLES`=100. Device stops clocking after 4 falling edges → done tick 100 cycles after the 4th `fall_edge`. `timeout_err` = 1, both `oe` = 0, `tx_idle` = 1.
- 3-cycle low glitch on `ps2c` during `data` → no shift; the frame still completes with correct bits. `wr_ps2` pulsed mid-frame → ignored.
- `reset` asserted low during `data` → `ps2c_oe` = `ps2d_oe` = 0 and `tx_idle` = 1 immediately; no `tx_done_tick`. A new 0xED transfer after release succeeds.

Source files
------------

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx -- host-to-device PS/2 transmitter
//
// Sends one command byte to a PS/2 device using the open-drain
// request-to-send sequence:
//   1. Inhibit the clock.
//   2. Hold the start bit.
//   3. Let the device clock out 8 data bits and an odd parity bit.
//   4. Release the data line for the stop bit.
//   5. Sample the device ACK.
// Any keyboard receive path sharing the lines should be gated with
// rx_en = tx_idle so that this frame is not decoded as a scan code.
//
// Ports
//   clk           system clock
//   reset         asynchronous reset, active low
//   wr_ps2        start-transfer strobe (only honoured while idle)
//   din[7:0]      command byte, captured on the accepted wr_ps2 cycle
//   ps2c, ps2d    PS/2 clock / data line levels (ps2c already synchronised)
//   ps2c_oe       1 = pull ps2c low, 0 = release
//   ps2d_oe       1 = pull ps2d low, 0 = release
//   tx_idle       1 while idle and ready for wr_ps2
//   tx_done_tick  one-cycle pulse when a transfer finishes or aborts
//   ack_err       1 = device did not acknowledge (valid from done tick)
//   timeout_err   1 = transfer aborted by the watchdog (valid from done tick)
// ---------------------------------------------------------------------------
module ps2_tx #(
  parameter int RTS_CYCLES     = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err,
  output logic       timeout_err
);

  // RTS_CYCLES-1 always fits in clog2(RTS_CYCLES) bits
  localparam int DW = (RTS_CYCLES > 2) ? $clog2(RTS_CYCLES) : 1;
  localparam logic [DW-1:0] RTS_LOAD = DW'(RTS_CYCLES - 1);
  localparam logic [19:0]   WD_LOAD  = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_reg,   state_next;
  logic [7:0]    filter_reg,  filter_next;
  logic          f_ps2c_reg,  f_ps2c_next;
  logic [8:0]    shift_reg,   shift_next;
  logic [DW-1:0] dly_reg,     dly_next;
  logic [19:0]   wd_reg,      wd_next;
  logic [3:0]    bit_reg,     bit_next;
  logic          done_reg,    done_next;
  logic          ack_reg,     ack_next;
  logic          tout_reg,    tout_next;
  logic          fall_edge;
  logic          wd_expired;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      filter_reg <= '1;
      f_ps2c_reg <= 1'b1;
      shift_reg  <= '0;
      dly_reg    <= '0;
      wd_reg     <= '0;
      bit_reg    <= '0;
      done_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      tout_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      filter_reg <= filter_next;
      f_ps2c_reg <= f_ps2c_next;
      shift_reg  <= shift_next;
      dly_reg    <= dly_next;
      wd_reg     <= wd_next;
      bit_reg    <= bit_next;
      done_reg   <= done_next;
      ack_reg    <= ack_next;
      tout_reg   <= tout_next;
    end
  end

  // -------------------------------------------------------------------------
  // Clock glitch filter: the filtered level only changes after 8 identical
  // samples. fall_edge is decoded combinationally from the registered
  // level, so the FSM consumes it on the edge that registers the new level.
  // -------------------------------------------------------------------------
  always_comb begin
    filter_next = {ps2c, filter_reg[7:1]};
    f_ps2c_next = f_ps2c_reg;
    if (filter_reg == 8'hFF) begin
      f_ps2c_next = 1'b1;
    end else if (filter_reg == 8'h00) begin
      f_ps2c_next = 1'b0;
    end
    fall_edge = f_ps2c_reg & ~f_ps2c_next;
  end

  // A falling edge in the same cycle as expiry counts as device activity
  assign wd_expired = (wd_reg == 20'd0) && !fall_edge;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    dly_next   = dly_reg;
    wd_next    = wd_reg;
    bit_next   = bit_reg;
    done_next  = 1'b0;
    ack_next   = ack_reg;
    tout_next  = tout_reg;

    // Watchdog runs while waiting on device clocks
    if (state_reg == START || state_reg == DATA || state_reg == STOP) begin
      if (fall_edge) begin
        wd_next = WD_LOAD;
      end else if (wd_reg != 20'd0) begin
        wd_next = wd_reg - 20'd1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (wr_ps2) begin
          shift_next = {~^din, din};
          dly_next   = RTS_LOAD;
          ack_next   = 1'b0;
          tout_next  = 1'b0;
          state_next = RTS;
        end
      end
      RTS: begin
        if (dly_reg == '0) begin
          wd_next    = WD_LOAD;
          state_next = START;
        end else begin
          dly_next = dly_reg - 1'b1;
        end
      end
      START, DATA, STOP: begin
        if (wd_expired) begin
          tout_next  = 1'b1;
          ack_next   = 1'b1;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (fall_edge) begin
          if (state_reg == START) begin
            bit_next   = 4'd8;
            state_next = DATA;
          end else if (state_reg == DATA) begin
            shift_next = {1'b0, shift_reg[8:1]};
            if (bit_reg == 4'd0) begin
              state_next = STOP;
            end else begin
              bit_next = bit_reg - 4'd1;
            end
          end else begin
            // Device pulls data low during this clock to acknowledge
            ack_next   = ps2d;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Line drivers decode straight from the state register so that an
  // asynchronous reset releases both lines immediately.
  // -------------------------------------------------------------------------
  assign ps2c_oe      = (state_reg == RTS);
  assign ps2d_oe      = (state_reg == START) ||
                        ((state_reg == DATA) && !shift_reg[0]);
  assign tx_idle      = (state_reg == IDLE);
  assign tx_done_tick = done_reg;
  assign ack_err      = ack_reg;
  assign timeout_err  = tout_reg;

endmodule

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx -- self-checking bench for ps2_tx
//
// A behavioural PS/2 device drives the open-drain lines. The line seen by
// the device at each clock fall is compared with the frame derived directly
// from the command byte: start 0, data LSB first, odd parity, stop 1.
// Done latency, ACK/timeout status and line release are checked per transfer.
// ---------------------------------------------------------------------------
module tb_ps2_tx;

  localparam int RTS = 20;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic       ps2c, ps2d;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err, timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;
  int both_low = 0;

  // Wired-AND open-drain lines with pull-ups
  assign ps2c = ~(ps2c_oe | dev_c_low);
  assign ps2d = ~(ps2d_oe | dev_d_low);

  ps2_tx #(
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err     (ack_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done_tick) done_count <= done_count + 1;
    if (ps2c_oe && ps2d_oe) both_low <= both_low + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Frame as the device should see it, index = order of clock falls
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_idle && n < 1000) begin
      step;
      n++;
    end
    check_val("idle_before_wr", tx_idle, 1);
    din = d;
    wr_ps2 = 1'b1;
    step;
    wr_ps2 = 1'b0;
    din = 8'($urandom);
    check_val("idle_falls", tx_idle, 0);
    check_val("done_one_cycle", tx_done_tick, 0);
    check_val("errs_cleared", {ack_err, timeout_err}, 0);
    n = 0;
    while (ps2c_oe && n < 10000) begin
      n++;
      step;
    end
    check_val("rts_len", n, RTS);
    check_val("start_bit_oe", ps2d_oe, 1);
  endtask

  task automatic run_frame(input int nfalls, input bit ack, input int glitch_k,
                           input bit wr_mid, output logic [10:0] bits,
                           output int done_ofs, output bit got_done);
    int last;
    int n;
    bits = '0;
    last = cyc;
    // Let the filter see the released clock as high before the first fall
    repeat ($urandom_range(12, 20)) step;
    for (int k = 0; k < nfalls; k++) begin
      bits[k] = ps2d;
      if (k == 10 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      last = cyc;
      if (k == nfalls - 1) break;
      repeat ($urandom_range(10, 16)) step;
      dev_c_low = 1'b0;
      if (k == glitch_k) begin
        repeat (9) step;
        dev_c_low = 1'b1;
        repeat (3) step;
        dev_c_low = 1'b0;
      end
      if (wr_mid && k == 5) begin
        wr_ps2 = 1'b1;
        din = 8'($urandom);
        step;
        wr_ps2 = 1'b0;
      end
      repeat ($urandom_range(10, 16)) step;
    end
    got_done = 1'b0;
    n = 0;
    while (!got_done && n < TO + 200) begin
      step;
      n++;
      if (tx_done_tick) got_done = 1'b1;
    end
    done_ofs = cyc - last;
  endtask

  task automatic do_txn(input logic [7:0] d, input int nfalls, input bit ack,
                        input int glitch_k, input bit wr_mid);
    logic [10:0] bits;
    logic [10:0] expb;
    logic [10:0] mask;
    int ofs;
    bit got;
    int dc;
    start_tx(d);
    run_frame(nfalls, ack, glitch_k, wr_mid, bits, ofs, got);
    expb = model_frame(d);
    mask = 11'((1 << nfalls) - 1);
    $display("txn din=%02h falls=%0d ack=%0b glitch=%0d wr_mid=%0b bits=%03h exp=%03h ofs=%0d ack_err=%0b timeout_err=%0b",
             d, nfalls, ack, glitch_k, wr_mid, bits & mask, expb & mask, ofs, ack_err, timeout_err);
    check_val("done_seen", got, 1);
    check_val("done_latency", ofs, (nfalls == 11) ? 9 : 9 + TO);
    check_val("line_bits", bits & mask, expb & mask);
    check_val("ack_err", ack_err, (nfalls == 11) ? !ack : 1);
    check_val("timeout_err", timeout_err, (nfalls < 11) ? 1 : 0);
    check_val("idle_at_done", tx_idle, 1);
    check_val("oe_at_done", {ps2c_oe, ps2d_oe}, 0);
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    if (wr_mid) begin
      dc = done_count;
      repeat (40) step;
      check_val("wr_mid_ignored_idle", tx_idle, 1);
      check_val("wr_mid_no_rts", ps2c_oe, 0);
      check_val("wr_mid_no_extra_done", done_count - dc, 1);
    end
  endtask

  initial begin
    int dc;
    repeat (3) step;
    check_val("rst_idle", tx_idle, 1);
    check_val("rst_oe", {ps2c_oe, ps2d_oe}, 0);
    check_val("rst_done", tx_done_tick, 0);
    check_val("rst_errs", {ack_err, timeout_err}, 0);
    reset = 1'b1;
    repeat (3) step;

    // Directed transfers
    do_txn(8'hED, 11, 1'b1, -1, 1'b0);
    do_txn(8'hF4, 11, 1'b1, -1, 1'b0);
    do_txn(8'hA5, 11, 1'b0, -1, 1'b0);
    do_txn(8'($urandom), 4, 1'b1, -1, 1'b0);
    do_txn(8'($urandom), 11, 1'b1, 4, 1'b1);

    // Randomised transfers, back-to-back with the previous done tick
    for (int i = 0; i < 14; i++) begin
      int nf;
      nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 11;
      do_txn(8'($urandom), nf, 1'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : -1, 1'b0);
    end

    // Reset in the middle of the data phase
    start_tx(8'h3C);
    repeat (14) step;
    for (int k = 0; k < 5; k++) begin
      dev_c_low = 1'b1;
      repeat (12) step;
      dev_c_low = 1'b0;
      repeat (12) step;
    end
    check_val("mid_data_busy", tx_idle, 0);
    dc = done_count;
    reset = 1'b0;
    #1;
    check_val("async_rst_oe", {ps2c_oe, ps2d_oe}, 0);
    check_val("async_rst_idle", tx_idle, 1);
    repeat (5) step;
    check_val("async_rst_no_done", done_count - dc, 0);
    $display("txn reset mid-data oe=%0b%0b idle=%0b", ps2c_oe, ps2d_oe, tx_idle);
    reset = 1'b1;
    repeat (3) step;
    do_txn(8'hED, 11, 1'b1, -1, 1'b0);

    check_val("never_both_oe", both_low, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
